ft2232_rx_framer: RTL
=====================

FT2232_RX_FRAMER -- requirements
Module: ft2232_rx_framer

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 Parameter MAX_LEN, default 64, maximum payload length in bytes (1..255).
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, maximum inter-byte gap inside a frame.
REQ-004 fifo_clk_i  in  1  clock; all logic on its rising edge.
REQ-005 reset_i  in  1  reset, asynchronous, active-high.
REQ-006 rx_valid_i  in  1  byte available from the FT2232 FIFO read stage.
REQ-007 rx_data_i  in  8  received byte.
REQ-008 rx_ready_o  out  1  framer accepts the byte this cycle.
REQ-009 pl_valid_o  out  1  validated payload byte available.
REQ-010 pl_data_o  out  8  payload byte.
REQ-011 pl_last_o  out  1  final payload byte of the frame.
REQ-012 pl_ready_i  in  1  downstream consumer accepts the payload byte.
REQ-013 pkt_done_o  out  1  one-cycle pulse; good frame fully delivered.
REQ-014 pkt_err_o  out  1  one-cycle pulse; frame discarded.
REQ-015 err_code_o  out  2  cause of the last error: 1 bad length, 2 checksum, 3 timeout.
REQ-016 pkt_count_o  out  16  good-frame count; wraps at 0xFFFF->0.
REQ-017 err_count_o  out  16  error count; saturates at 0xFFFF.

Function
REQ-018 Frame format: SYNC_BYTE, LEN, LEN payload bytes, CHK; (LEN + sum of payload + CHK) mod 256 SHALL equal 0.
REQ-019 An input byte SHALL transfer only in a cycle where rx_valid_i=1 and rx_ready_o=1.
REQ-020 A payload byte SHALL transfer only in a cycle where pl_valid_o=1 and pl_ready_i=1.
REQ-021 States: HUNT, LEN, PAYLOAD, CHK, EMIT; rx_ready_o=1 in HUNT/LEN/PAYLOAD/CHK, 0 in EMIT.
REQ-022 HUNT: accepted byte equal to SYNC_BYTE -> LEN; any other byte is dropped silently, with no error.
REQ-023 LEN: accepted byte 0 or >MAX_LEN -> pkt_err_o, err_code_o=1, HUNT; otherwise latch the length, seed the 8-bit sum with LEN and go to PAYLOAD.
REQ-024 PAYLOAD: each accepted byte is written to the internal MAX_LEN x 8 buffer at index 0..LEN-1 and added to the sum; after the LEN-th byte -> CHK.
REQ-025 CHK: accepted byte with (sum + byte) mod 256 = 0 -> EMIT; otherwise pkt_err_o, err_code_o=2, HUNT, and the buffer contents are discarded.
REQ-026 EMIT: pl_valid_o SHALL assert the cycle after the CHK byte is accepted; buffer bytes are presented in order 0..LEN-1, and each stays stable until it transfers.
REQ-027 pl_last_o=1 only while byte LEN-1 is presented.
REQ-028 A full-rate consumer (pl_ready_i held 1) SHALL receive one byte per cycle with no bubbles.
REQ-029 Transfer of the last byte -> HUNT; pkt_done_o pulses the following cycle and pkt_count_o increments in that same cycle.
REQ-030 Timeout: in LEN, PAYLOAD or CHK, after TIMEOUT_CYCLES consecutive cycles without an accepted byte -> pkt_err_o, err_code_o=3, HUNT. EMIT and HUNT have no timeout.
REQ-031 Every pkt_err_o pulse increments err_count_o, saturating at 0xFFFF; err_code_o holds its value until the next error.
REQ-032 A SYNC_BYTE value inside LEN/PAYLOAD/CHK is treated as data; there is no resynchronisation mid-frame.
REQ-033 pkt_done_o and pkt_err_o SHALL never assert in the same cycle.

Reset
REQ-034 While reset_i=1: state HUNT; rx_ready_o=0; pl_valid_o, pl_last_o, pkt_done_o, pkt_err_o=0; err_code_o=0; counters=0; pl_data_o=0.
REQ-035 Reset asserted mid-frame or mid-EMIT SHALL abort the frame immediately, with no error pulse and no counter change; rx_ready_o=1 from the first clock after release.

Verification
REQ-036 Good frame: A5 03 11 22 33 97, pl_ready_i=1 -> payload 11,22,33 on consecutive cycles; pl_last_o with 33; pkt_done_o=1 once; pkt_count_o=1.
REQ-037 Bad checksum: A5 02 10 20 00 -> no pl_valid_o; pkt_err_o=1, err_code_o=2, err_count_o=1; a following good frame is delivered correctly.
REQ-038 Bad length: A5 00, then A5 41 with MAX_LEN=64 -> two errors with err_code_o=1, err_count_o=2; garbage bytes 00 FF before the next A5 raise no error.
REQ-039 Backpressure: good 4-byte frame with pl_ready_i toggling 1/0 -> each byte held stable while not accepted; rx_ready_o=0 throughout EMIT; all bytes are delivered in order.
REQ-040 Timeout: A5 05 01 followed by a TIMEOUT_CYCLES idle gap -> pkt_err_o exactly TIMEOUT_CYCLES cycles after byte 01, err_code_o=3; a frame starting one cycle earlier does not time out.
REQ-041 Reset during EMIT of the second byte -> pl_valid_o=0 immediately; pkt_count_o unchanged; a subsequent good frame is delivered intact.

Source files
------------

// File: rtl/ft2232_rx_framer_if.sv
// Byte-stream handshakes around the FT2232 receive framer:
// FIFO-side input bytes and validated payload output bytes.
interface ft2232_rx_framer_if;
    logic       rx_valid_i;
    logic [7:0] rx_data_i;
    logic       rx_ready_o;
    logic       pl_valid_o;
    logic [7:0] pl_data_o;
    logic       pl_last_o;
    logic       pl_ready_i;

    modport slave (
        input  rx_valid_i, rx_data_i, pl_ready_i,
        output rx_ready_o, pl_valid_o, pl_data_o, pl_last_o
    );

    modport master (
        output rx_valid_i, rx_data_i, pl_ready_i,
        input  rx_ready_o, pl_valid_o, pl_data_o, pl_last_o
    );
endinterface

// File: rtl/ft2232_rx_framer.sv
// Frames SYNC/LEN/payload/CHK byte streams from the FT2232 FIFO,
// buffers the payload and releases it only once the checksum is good.
module ft2232_rx_framer #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 64,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                      fifo_clk_i,
    input  logic                      reset_i,
    ft2232_rx_framer_if.slave         bus,
    output logic                      pkt_done_o,
    output logic                      pkt_err_o,
    output logic [1:0]                err_code_o,
    output logic [15:0]               pkt_count_o,
    output logic [15:0]               err_count_o
);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]    MAX_L  = 8'(MAX_LEN);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_EMIT
    } state_t;

    state_t state, nxt;

    logic [7:0]    mem [MAX_LEN];
    logic [7:0]    len, sum, wr_idx, rd_idx;
    logic [TW-1:0] idle_cnt;
    logic          live;
    logic          rx_acc, pl_acc, in_frame, timed_out;
    logic [7:0]    sum_chk;
    logic          err_set, done_set;
    logic [1:0]    err_code_n;

    assign bus.rx_ready_o = live && (state != S_EMIT);
    assign bus.pl_valid_o = (state == S_EMIT);
    assign bus.pl_data_o  = (state == S_EMIT) ? mem[rd_idx[IW-1:0]] : 8'h00;
    assign bus.pl_last_o  = (state == S_EMIT) && (rd_idx == len - 8'd1);

    assign rx_acc    = bus.rx_valid_i && bus.rx_ready_o;
    assign pl_acc    = bus.pl_valid_o && bus.pl_ready_i;
    assign in_frame  = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
    assign timed_out = in_frame && !rx_acc && (idle_cnt == T_LAST);
    assign sum_chk   = sum + bus.rx_data_i;

    always_ff @(posedge fifo_clk_i or posedge reset_i) begin
        if (reset_i) state <= S_HUNT;
        else         state <= nxt;
    end

    always_comb begin
        nxt        = state;
        err_set    = 1'b0;
        err_code_n = 2'd0;
        done_set   = 1'b0;
        unique case (state)
            S_HUNT: begin
                if (rx_acc && bus.rx_data_i == SYNC_BYTE) nxt = S_LEN;
            end
            S_LEN: begin
                if (rx_acc) begin
                    if (bus.rx_data_i == 8'd0 || bus.rx_data_i > MAX_L) begin
                        nxt        = S_HUNT;
                        err_set    = 1'b1;
                        err_code_n = 2'd1;
                    end else begin
                        nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_acc && wr_idx == len - 8'd1) nxt = S_CHK;
            end
            S_CHK: begin
                if (rx_acc) begin
                    if (sum_chk == 8'd0) begin
                        nxt = S_EMIT;
                    end else begin
                        nxt        = S_HUNT;
                        err_set    = 1'b1;
                        err_code_n = 2'd2;
                    end
                end
            end
            S_EMIT: begin
                if (pl_acc && bus.pl_last_o) begin
                    nxt      = S_HUNT;
                    done_set = 1'b1;
                end
            end
            default: nxt = S_HUNT;
        endcase
        // Inter-byte gap expiry overrides whatever the frame state wanted
        if (timed_out) begin
            nxt        = S_HUNT;
            err_set    = 1'b1;
            err_code_n = 2'd3;
        end
    end

    always_ff @(posedge fifo_clk_i) begin
        if (state == S_PAYLOAD && rx_acc) mem[wr_idx[IW-1:0]] <= bus.rx_data_i;
    end

    always_ff @(posedge fifo_clk_i or posedge reset_i) begin
        if (reset_i) begin
            live        <= 1'b0;
            len         <= 8'd0;
            sum         <= 8'd0;
            wr_idx      <= 8'd0;
            rd_idx      <= 8'd0;
            idle_cnt    <= '0;
            pkt_done_o  <= 1'b0;
            pkt_err_o   <= 1'b0;
            err_code_o  <= 2'd0;
            pkt_count_o <= 16'd0;
            err_count_o <= 16'd0;
        end else begin
            live       <= 1'b1;
            pkt_done_o <= done_set;
            pkt_err_o  <= err_set;
            if (rx_acc || !in_frame) idle_cnt <= '0;
            else                     idle_cnt <= idle_cnt + 1'b1;
            if (state == S_LEN && rx_acc) begin
                len    <= bus.rx_data_i;
                sum    <= bus.rx_data_i;
                wr_idx <= 8'd0;
            end
            if (state == S_PAYLOAD && rx_acc) begin
                sum    <= sum_chk;
                wr_idx <= wr_idx + 8'd1;
            end
            if (state == S_CHK) rd_idx <= 8'd0;
            else if (pl_acc)    rd_idx <= rd_idx + 8'd1;
            if (done_set) pkt_count_o <= pkt_count_o + 16'd1;
            if (err_set) begin
                err_code_o <= err_code_n;
                if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
            end
        end
    end
endmodule
